light_pen_rx: RTL
=================

// Module: light_pen_rx
// PURPOSE
//  Receive side of the light-pen interface. Samples the photodiode input and correlates a
//  confirmed light pulse with the delayed LED-matrix scan position. Emits a one-cycle write
//  strobe plus binary row/col coordinates to the display RAM path. Sits between the pen
//  pad and the LED driver's "we" input.
// PARAMETERS
//  SYNC_STAGES   2     flops in pen_in synchroniser (>=2)
//  ALIGN_DLY     3     cycles scan position is delayed to match pen optical/sync latency (1..15)
//  GLITCH_CYC    4     consecutive high samples required to confirm a pulse (>=1)
//  HOLDOFF_CYC   1024  dead time after a hit before re-arming (>=1)
//  CNT_W         16    width of holdoff/confirm counter and err_cnt
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  pen_in       in   1      raw photodiode comparator output, asynchronous, high = light seen
//  scan_row     in   8      one-hot row currently driven by scanner (active-high, pre-inversion)
//  scan_col     in   8      one-hot column currently driven by scanner
//  enable       in   1      0 = detector held in IDLE, no hits
//  hit          out  1      one-cycle write strobe
//  hit_row      out  3      binary row of last hit, valid when hit=1, held afterwards
//  hit_col      out  3      binary col of last hit, valid when hit=1, held afterwards
//  pen_present  out  1      synchronised pen level
//  err_cnt      out  CNT_W  count of discarded candidates (bad one-hot), saturating
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; sync chain and scan delay line cleared to 0.
//  - pen_s = pen_in after SYNC_STAGES flops; pen_present = pen_s.
//  - scan_row/scan_col pass through an ALIGN_DLY-deep shift register -> row_d/col_d.
//  - FSM:
//    IDLE:     enable && pen_s -> CONFIRM, cnt=1, latch cand = {row_d,col_d}.
//    CONFIRM:  pen_s=0 -> IDLE (glitch, no count). pen_s=1: cnt++; cnt==GLITCH_CYC -> CHECK.
//              With GLITCH_CYC=1, CHECK is entered directly from IDLE.
//    CHECK:    one cycle. cand row and col each exactly one bit set -> HIT;
//              else err_cnt++ (saturate at all-ones) -> WAIT_LOW.
//    HIT:      hit=1 for this cycle only; hit_row/hit_col = encoded cand; -> HOLDOFF, cnt=0.
//    HOLDOFF:  cnt++ each cycle; cnt==HOLDOFF_CYC-1 -> WAIT_LOW.
//    WAIT_LOW: pen_s=0 -> IDLE. Pen held on the panel never produces a second hit.
//  - Candidate position is the scan position at the first high sample, not the confirm cycle.
//  - Latency: pen_in rise -> hit = SYNC_STAGES + GLITCH_CYC + 1 cycles (+1 CHECK).
//  - enable deasserted in any state -> IDLE next cycle; hit never asserted that cycle.
//  - rst mid-sequence aborts immediately; no pending hit is emitted after release.
//  - One-hot encode: bit i -> i (bit0 -> 0, bit7 -> 7); all-zero or multi-bit -> error path.
//  - err_cnt cleared only by rst.
// CONFIGURATION
//  LPEN_FRAME_VOTE_EN defined: adds input frame_start (1 bit, pulse at scan frame start).
//   HIT requires cand equal to the candidate confirmed in the previous frame; mismatch,
//   or no candidate last frame, stores cand as reference and goes to WAIT_LOW without hit.
//   Reference cleared on rst and when a frame ends without a candidate.
//  Undefined: no frame_start port; every valid candidate produces a hit.
// TESTING
//  1 rst=1 then release, pen_in=0 -> hit=0, hit_row=hit_col=0, err_cnt=0, FSM IDLE.
//  2 scan_row=8'h04, scan_col=8'h20 aligned; pen_in high 10 cycles -> one hit after
//    SYNC_STAGES+GLITCH_CYC+2 cycles, hit_row=2, hit_col=5.
//  3 pen_in high 3 cycles (GLITCH_CYC=4) -> no hit, err_cnt unchanged.
//  4 pen_in high while scan_row=8'h00 after delay -> no hit, err_cnt=1.
//  5 pen_in high 5000 cycles -> exactly one hit; drop low 5 then high again -> second hit.
//  6 rst asserted in CONFIRM and in HOLDOFF -> outputs 0 at once, no hit after release.
//    (Vote build) same position two frames -> one hit on frame 2; differing -> none.

Source files
------------

// File: rtl/light_pen_rx_if.sv
// Pen-pad / scanner / display-RAM signals of the light-pen receiver.
// LPEN_FRAME_VOTE_EN adds the frame_start input.
interface light_pen_if #(parameter int CNT_W = 16);
   logic             pen_in;
   logic [7:0]       scan_row;
   logic [7:0]       scan_col;
   logic             enable;
`ifdef LPEN_FRAME_VOTE_EN
   logic             frame_start;
`endif
   logic             hit;
   logic [2:0]       hit_row;
   logic [2:0]       hit_col;
   logic             pen_present;
   logic [CNT_W-1:0] err_cnt;

`ifdef LPEN_FRAME_VOTE_EN
   modport master (output pen_in, scan_row, scan_col, enable, frame_start,
                   input  hit, hit_row, hit_col, pen_present, err_cnt);
   modport slave  (input  pen_in, scan_row, scan_col, enable, frame_start,
                   output hit, hit_row, hit_col, pen_present, err_cnt);
`else
   modport master (output pen_in, scan_row, scan_col, enable,
                   input  hit, hit_row, hit_col, pen_present, err_cnt);
   modport slave  (input  pen_in, scan_row, scan_col, enable,
                   output hit, hit_row, hit_col, pen_present, err_cnt);
`endif
endinterface

// File: rtl/light_pen_rx.sv
// Light-pen receiver: pen sync, glitch filter, scan-position correlation, hit strobe.
// LPEN_FRAME_VOTE_EN: a hit needs the same position confirmed in two consecutive frames.
module light_pen_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int ALIGN_DLY   = 3,
   parameter int GLITCH_CYC  = 4,
   parameter int HOLDOFF_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   light_pen_if.slave lp
);
   typedef enum logic [2:0] {IDLE, CONFIRM, CHECK, HIT, HOLDOFF, WAIT_LOW} state_e;

   localparam logic [CNT_W-1:0] GLITCH_N  = CNT_W'(GLITCH_CYC);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

   state_e                      state_q, state_d;
   logic [SYNC_STAGES-1:0]      sync_q, sync_d;
   logic [ALIGN_DLY-1:0][15:0]  dly_q, dly_d;
   logic [15:0]                 cand_q, cand_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d, err_q, err_d, cnt_inc;
   logic                        hit_q, hit_d;
   logic [2:0]                  hrow_q, hrow_d, hcol_q, hcol_d;
   logic                        pen_s, cand_ok, vote_ok;
   logic [15:0]                 pos;

   function automatic logic onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   function automatic logic [2:0] enc8(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) r = 3'(i);
      return r;
   endfunction

   assign pen_s   = sync_q[SYNC_STAGES-1];
   assign pos     = dly_q[ALIGN_DLY-1];
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign cand_ok = onehot8(cand_q[15:8]) && onehot8(cand_q[7:0]);

`ifdef LPEN_FRAME_VOTE_EN
   logic [15:0] ref_q, ref_d;
   logic        ref_vld_q, ref_vld_d, seen_q, seen_d;
   assign vote_ok = ref_vld_q && (ref_q == cand_q);
`else
   assign vote_ok = 1'b1;
`endif

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], lp.pen_in};
      dly_d[0] = {lp.scan_row, lp.scan_col};
      for (int i = 1; i < ALIGN_DLY; i++) dly_d[i] = dly_q[i-1];
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      err_d   = err_q;
      hit_d   = 1'b0;
      hrow_d  = hrow_q;
      hcol_d  = hcol_q;
`ifdef LPEN_FRAME_VOTE_EN
      ref_d     = ref_q;
      ref_vld_d = ref_vld_q;
      seen_d    = seen_q;
      // A frame that closes with no confirmed candidate forgets the reference.
      if (lp.frame_start) begin
         seen_d = 1'b0;
         if (!seen_q) ref_vld_d = 1'b0;
      end
`endif
      if (!lp.enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (pen_s) begin
               // Position is taken at the first high sample, not at confirmation.
               cand_d  = pos;
               cnt_d   = CNT_W'(1);
               state_d = (GLITCH_CYC == 1) ? CHECK : CONFIRM;
            end
            CONFIRM: if (!pen_s) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == GLITCH_N) state_d = CHECK;
            end
            CHECK: begin
               if (cand_ok && vote_ok) begin
                  state_d = HIT;
                  hit_d   = 1'b1;
                  hrow_d  = enc8(cand_q[15:8]);
                  hcol_d  = enc8(cand_q[7:0]);
               end else begin
                  if (!cand_ok) begin
                     if (err_q != '1) err_d = err_q + CNT_W'(1);
                  end
`ifdef LPEN_FRAME_VOTE_EN
                  else begin
                     ref_d     = cand_q;
                     ref_vld_d = 1'b1;
                  end
`endif
                  state_d = WAIT_LOW;
               end
`ifdef LPEN_FRAME_VOTE_EN
               if (cand_ok) seen_d = 1'b1;
`endif
            end
            HIT: begin
               state_d = HOLDOFF;
               cnt_d   = '0;
            end
            HOLDOFF: if (cnt_q == HOLD_LAST) state_d = WAIT_LOW;
                     else                    cnt_d   = cnt_inc;
            WAIT_LOW: if (!pen_s) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         dly_q   <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         hit_q   <= 1'b0;
         hrow_q  <= '0;
         hcol_q  <= '0;
`ifdef LPEN_FRAME_VOTE_EN
         ref_q     <= '0;
         ref_vld_q <= 1'b0;
         seen_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         dly_q   <= dly_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         hit_q   <= hit_d;
         hrow_q  <= hrow_d;
         hcol_q  <= hcol_d;
`ifdef LPEN_FRAME_VOTE_EN
         ref_q     <= ref_d;
         ref_vld_q <= ref_vld_d;
         seen_q    <= seen_d;
`endif
      end
   end

   assign lp.hit         = hit_q;
   assign lp.hit_row     = hrow_q;
   assign lp.hit_col     = hcol_q;
   assign lp.pen_present = pen_s;
   assign lp.err_cnt     = err_q;
endmodule
